bcd_calc_core: RTL and testbench
================================

Name: bcd_calc_core

Overview:
- Parametrised successor to the fixed 4-digit keypad calculator datapath.
- Accepts decoded key codes from the PS/2 front end and holds two DIGITS-wide BCD operands.
- Performs digit-serial add or subtract, one digit per cycle; a negative difference is converted to a signed magnitude.
- Drives the multiplexed display block with the operand being entered or the result, plus sign, overflow and busy status.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result; legal range 2..8.
- CNT_W, 3, width of the entry and digit counters; must satisfy 2^CNT_W > DIGITS.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset; asynchronous, active-high.
- key_i  input  4  key code: 0-9 digit, 10 '+', 11 '-', 12 '=', 13 clear, 14 backspace, 15 ignored.
- key_valid_i  input  1  single-cycle strobe qualifying key_i.
- disp_o  output  4*DIGITS  displayed BCD digits; digit i is bits [4i+3:4i], digit 0 is least significant.
- neg_o  output  1  displayed result is negative.
- ovf_o  output  1  addition carried out of the most significant digit.
- busy_o  output  1  CALC or COMPL in progress.
- done_o  output  1  one-cycle pulse when a result becomes valid.
- blank_o  output  DIGITS  leading-zero blank mask; see Optional Feature.

Behaviour:
- Reset values: operands A and B = 0; entry counts = 0; op = add; state ENTRY_A; disp_o = 0; neg_o, ovf_o, busy_o, done_o and blank_o all 0.
- States: ENTRY_A, ENTRY_B, CALC, COMPL, RESULT. All outputs are registered.
- Keys are sampled only on cycles where key_valid_i = 1. Key 15 is ignored in every state.
- ENTRY_A / ENTRY_B, digit key:
  - Shift the active operand left one digit, insert the key at digit 0, increment its count.
  - If count already equals DIGITS, the key is ignored (no shift-out, no wrap).
- Backspace:
  - Shift the active operand right, insert 0 at the MSD, decrement count.
  - No-op when count = 0.
- Operator keys ('+' / '-'):
  - In ENTRY_A: latch op, clear B and its count, go to ENTRY_B.
  - In ENTRY_B: replace op only; B is unchanged.
- '=':
  - Ignored in ENTRY_A.
  - In ENTRY_B: go to CALC and clear the digit counter.
- disp_o shows A in ENTRY_A and B in ENTRY_B; it holds B during CALC and COMPL.
- CALC:
  - One digit per cycle, LSD first: 4-bit BCD add (+6 correction when the binary sum exceeds 9), or BCD subtract with borrow.
  - Exactly DIGITS cycles.
  - Add: final carry sets ovf_o; the result shown is the low DIGITS digits.
  - Subtract with no final borrow: result is non-negative, go to RESULT.
  - Subtract with a final borrow: go to COMPL.
- COMPL:
  - DIGITS cycles computing 0 - R (ten's complement), LSD first.
  - Sets neg_o, then goes to RESULT.
- Latency: '=' accepted at edge k; busy_o is high for cycles k+1 .. k+DIGITS, plus DIGITS more cycles when COMPL runs; done_o pulses with the first RESULT cycle.
- RESULT:
  - disp_o = result; neg_o and ovf_o are held.
  - Digit key: clear A, B, neg_o and ovf_o; load the digit into A (count = 1); go to ENTRY_A.
  - Operator key: if neg_o = 0 and ovf_o = 0, then A <= result, A count = DIGITS, latch op, clear B, go to ENTRY_B. Otherwise the key is ignored.
  - '=' and backspace are ignored.
- Clear (13) in any state, including CALC and COMPL: abort and return to the reset values on the next edge. done_o does not pulse.
- While busy_o = 1, every key except clear is ignored.
- rst_i asserted mid-calculation: immediate return to reset values; no done_o pulse.

Optional Feature:
- Macro: BCD_CALC_BLANK_EN.
- Defined:
  - blank_o[i] = 1 when disp_o digits i..DIGITS-1 are all zero and i > 0; digit 0 is never blanked.
  - Registered alongside disp_o and updated in the same cycle.
- Undefined: blank_o is constant 0, and no blanking logic is synthesised.

Test Plan (DIGITS = 4):
- Keys 1,2,3,4,5 -> disp_o = 0x1234 (fifth digit ignored); backspace -> 0x0123.
- 1,2,3,4 '+' 8,7,6,6 '=' -> busy_o high for 4 cycles, then done_o pulses; disp_o = 0x0000, ovf_o = 1, neg_o = 0.
- 2,5 '-' 1,0,0 '=' -> busy_o high for 8 cycles; disp_o = 0x0075, neg_o = 1.
- 9,9 '+' 1 '=' then '-' 5,0 '=' -> first result 0x0100; chained result 0x0050, neg_o = 0.
- 5 '+' 5 '=', then clear asserted on the 2nd busy cycle -> next cycle all outputs are 0, state ENTRY_A, no done_o pulse.
- With BCD_CALC_BLANK_EN, entering 4,2 -> blank_o = 4'b1100; after clear -> blank_o = 4'b1110.

Source files
------------

// File: rtl/bcd_calc_core.sv
// Digit-serial BCD keypad calculator datapath with operand entry, add/subtract and sign fix-up.
// Optional leading-zero blanking mask is built only when BCD_CALC_BLANK_EN is defined.
module bcd_calc_core #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            key_i,
  input  logic                  key_valid_i,
  output logic [4*DIGITS-1:0]   disp_o,
  output logic                  neg_o,
  output logic                  ovf_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIGITS-1:0]     blank_o
);

  localparam int unsigned W = 4 * DIGITS;

  localparam logic [2:0] ST_ENTRY_A = 3'd0;
  localparam logic [2:0] ST_ENTRY_B = 3'd1;
  localparam logic [2:0] ST_CALC    = 3'd2;
  localparam logic [2:0] ST_COMPL   = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGITS - 1);

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, dig_q, dig_d;
  logic             cy_q, cy_d;
  logic             op_q, op_d;  // 1 = subtract
  logic             neg_q, neg_d, ovf_q, ovf_d;
  logic [W-1:0]     disp_q, disp_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             key_dig, key_op, key_eq, key_clr, key_bksp;
  logic [3:0]       x_dig, y_dig, d_res;
  logic             d_cy, do_sub;
  logic [4:0]       sum5, diff5;
  logic [W-1:0]     opd;
  logic [CNT_W-1:0] ocnt;

  assign key_dig  = key_valid_i && (key_i <= 4'd9);
  assign key_op   = key_valid_i && ((key_i == 4'd10) || (key_i == 4'd11));
  assign key_eq   = key_valid_i && (key_i == 4'd12);
  assign key_clr  = key_valid_i && (key_i == 4'd13);
  assign key_bksp = key_valid_i && (key_i == 4'd14);

  // One BCD digit step; COMPL reuses the subtractor as 0 - R.
  always_comb begin
    do_sub = (state_q == ST_COMPL) || op_q;
    if (state_q == ST_COMPL) begin
      x_dig = 4'd0;
      y_dig = r_q[{dig_q, 2'b00} +: 4];
    end else begin
      x_dig = a_q[{dig_q, 2'b00} +: 4];
      y_dig = b_q[{dig_q, 2'b00} +: 4];
    end
    sum5  = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, cy_q};
    diff5 = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, cy_q};
    if (do_sub) begin
      d_cy  = diff5[4];
      d_res = diff5[4] ? (diff5[3:0] + 4'd10) : diff5[3:0];
    end else begin
      d_cy  = (sum5 > 5'd9);
      d_res = (sum5 > 5'd9) ? (sum5[3:0] + 4'd6) : sum5[3:0];
    end
  end

  // Shared entry editing for whichever operand is active.
  always_comb begin
    opd  = (state_q == ST_ENTRY_B) ? b_q : a_q;
    ocnt = (state_q == ST_ENTRY_B) ? cnt_b_q : cnt_a_q;
    if (key_dig && (ocnt != CNT_MAX)) begin
      opd  = {opd[W-5:0], key_i};
      ocnt = ocnt + CNT_W'(1);
    end else if (key_bksp && (ocnt != '0)) begin
      opd  = {4'h0, opd[W-1:4]};
      ocnt = ocnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    dig_d   = dig_q;
    cy_d    = cy_q;
    op_d    = op_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_ENTRY_A: begin
        a_d     = opd;
        cnt_a_d = ocnt;
        if (key_op) begin
          op_d    = key_i[0];
          b_d     = '0;
          cnt_b_d = '0;
          state_d = ST_ENTRY_B;
        end
      end
      ST_ENTRY_B: begin
        b_d     = opd;
        cnt_b_d = ocnt;
        if (key_op) begin
          op_d = key_i[0];
        end else if (key_eq) begin
          dig_d   = '0;
          cy_d    = 1'b0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        r_d[{dig_q, 2'b00} +: 4] = d_res;
        cy_d  = d_cy;
        dig_d = dig_q + CNT_W'(1);
        if (dig_q == DIG_LAST) begin
          if (!op_q) begin
            ovf_d   = d_cy;
            state_d = ST_RESULT;
          end else if (d_cy) begin
            dig_d   = '0;
            cy_d    = 1'b0;
            state_d = ST_COMPL;
          end else begin
            state_d = ST_RESULT;
          end
        end
      end
      ST_COMPL: begin
        r_d[{dig_q, 2'b00} +: 4] = d_res;
        cy_d  = d_cy;
        dig_d = dig_q + CNT_W'(1);
        if (dig_q == DIG_LAST) begin
          neg_d   = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (key_dig) begin
          a_d     = {{(W-4){1'b0}}, key_i};
          cnt_a_d = CNT_W'(1);
          b_d     = '0;
          cnt_b_d = '0;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_ENTRY_A;
        end else if (key_op && !neg_q && !ovf_q) begin
          a_d     = r_q;
          cnt_a_d = CNT_MAX;
          op_d    = key_i[0];
          b_d     = '0;
          cnt_b_d = '0;
          state_d = ST_ENTRY_B;
        end
      end
      default: state_d = ST_ENTRY_A;
    endcase

    if (key_clr) begin
      state_d = ST_ENTRY_A;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      dig_d   = '0;
      cy_d    = 1'b0;
      op_d    = 1'b0;
      neg_d   = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // Outputs are derived from next-state so they register in step with the FSM.
  always_comb begin
    case (state_d)
      ST_ENTRY_A: disp_d = a_d;
      ST_RESULT:  disp_d = r_d;
      default:    disp_d = b_d;
    endcase
    busy_d = (state_d == ST_CALC) || (state_d == ST_COMPL);
    done_d = (state_d == ST_RESULT) && (state_q != ST_RESULT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_ENTRY_A;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      dig_q   <= '0;
      cy_q    <= 1'b0;
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      dig_q   <= dig_d;
      cy_q    <= cy_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign disp_o = disp_q;
  assign neg_o  = neg_q;
  assign ovf_o  = ovf_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef BCD_CALC_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  always_comb begin
    blank_d = '0;
    for (int i = 1; i < DIGITS; i++) begin
      blank_d[i] = ((disp_d >> (4 * i)) == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_o = blank_q;
`else
  assign blank_o = '0;
`endif

endmodule

// File: tb/tb_bcd_calc_core.sv
// Directed bench for bcd_calc_core (DIGITS = 4) with hand-computed expected values.
module tb_bcd_calc_core;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  key_i = 4'd0;
  logic        key_valid_i = 1'b0;
  logic [15:0] disp_o;
  logic        neg_o, ovf_o, busy_o, done_o;
  logic [3:0]  blank_o;

  int n_checks = 0;
  int n_errors = 0;

  bcd_calc_core #(
    .DIGITS (4),
    .CNT_W  (3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .disp_o      (disp_o),
    .neg_o       (neg_o),
    .ovf_o       (ovf_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .blank_o     (blank_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One-cycle key strobe; returns on the falling edge after the capturing edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk_i);
    key_i       = k;
    key_valid_i = 1'b1;
    @(negedge clk_i);
    key_valid_i = 1'b0;
    key_i       = 4'd15;
  endtask

  task automatic wait_result(input string tag, input int exp_busy);
    int n;
    n = 0;
    while (busy_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    check_eq({tag, "_busy_cycles"}, n, exp_busy);
    check_eq({tag, "_done"}, {31'd0, done_o}, 1);
    @(negedge clk_i);
    check_eq({tag, "_done_end"}, {31'd0, done_o}, 0);
  endtask

  logic [3:0] exp_blank_clr, exp_blank_42;
  int         done_seen;

  initial begin
`ifdef BCD_CALC_BLANK_EN
    exp_blank_clr = 4'b1110;
    exp_blank_42  = 4'b1100;
`else
    exp_blank_clr = 4'b0000;
    exp_blank_42  = 4'b0000;
`endif
    #12;
    check_eq("rst_disp", {16'd0, disp_o}, 0);
    check_eq("rst_flags", {27'd0, neg_o, ovf_o, busy_o, done_o}, 0);
    check_eq("rst_blank", {28'd0, blank_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Entry, digit limit and backspace
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check_eq("entry_limit", {16'd0, disp_o}, 32'h1234);
    press(4'd14);
    check_eq("backspace", {16'd0, disp_o}, 32'h0123);
    press(4'd15);
    check_eq("key15_ignored", {16'd0, disp_o}, 32'h0123);
    press(4'd13);
    check_eq("clear_disp", {16'd0, disp_o}, 0);
    check_eq("clear_blank", {28'd0, blank_o}, {28'd0, exp_blank_clr});
    press(4'd14);
    check_eq("bksp_empty", {16'd0, disp_o}, 0);
    press(4'd4); press(4'd2);
    check_eq("entry_42", {16'd0, disp_o}, 32'h0042);
    check_eq("blank_42", {28'd0, blank_o}, {28'd0, exp_blank_42});
    press(4'd12);
    check_eq("eq_in_a_ignored", {15'd0, busy_o, disp_o}, 32'h0042);
    press(4'd13);

    // 1234 + 8766 = 10000 -> 0000 with overflow
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd10);
    check_eq("b_cleared", {16'd0, disp_o}, 0);
    press(4'd8); press(4'd7); press(4'd6); press(4'd6);
    check_eq("entry_b", {16'd0, disp_o}, 32'h8766);
    press(4'd12);
    check_eq("add_busy_hold_b", {15'd0, busy_o, disp_o}, 32'h18766);
    wait_result("add_ovf", 4);
    check_eq("add_ovf_disp", {16'd0, disp_o}, 0);
    check_eq("add_ovf_flags", {30'd0, neg_o, ovf_o}, 32'b01);
    press(4'd11);
    check_eq("op_after_ovf_ignored", {16'd0, disp_o}, 0);

    // Digit from RESULT starts fresh: 25 - 100 = -75
    press(4'd2);
    check_eq("restart_a", {14'd0, neg_o, ovf_o, disp_o}, 32'h0002);
    press(4'd5); press(4'd11);
    press(4'd1); press(4'd0); press(4'd0);
    press(4'd12);
    wait_result("sub_neg", 8);
    check_eq("sub_neg_disp", {16'd0, disp_o}, 32'h0075);
    check_eq("sub_neg_flags", {30'd0, neg_o, ovf_o}, 32'b10);
    press(4'd10);
    check_eq("op_after_neg_ignored", {15'd0, neg_o, disp_o}, 32'h10075);
    press(4'd13);
    check_eq("clear_neg", {31'd0, neg_o}, 0);

    // 99 + 1 = 100, then chained - 50 = 50
    press(4'd9); press(4'd9); press(4'd10); press(4'd1); press(4'd12);
    wait_result("add_carry", 4);
    check_eq("add_carry_disp", {14'd0, neg_o, ovf_o, disp_o}, 32'h0100);
    press(4'd11);
    check_eq("chain_b_clear", {16'd0, disp_o}, 0);
    press(4'd5); press(4'd0); press(4'd12);
    wait_result("chain_sub", 4);
    check_eq("chain_disp", {14'd0, neg_o, ovf_o, disp_o}, 32'h0050);
    press(4'd13);

    // Op replaced in ENTRY_B: 7 + (changed to -) 3 = 4
    press(4'd7); press(4'd10); press(4'd3); press(4'd11); press(4'd12);
    wait_result("op_replace", 4);
    check_eq("op_replace_disp", {14'd0, neg_o, ovf_o, disp_o}, 32'h0004);
    press(4'd13);

    // Clear on the second busy cycle aborts with no done pulse
    press(4'd5); press(4'd10); press(4'd5); press(4'd12);
    check_eq("abort_busy1", {31'd0, busy_o}, 1);
    press(4'd13);
    check_eq("abort_outputs", {12'd0, neg_o, ovf_o, busy_o, done_o, disp_o}, 0);
    done_seen = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (done_o) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);
    press(4'd7);
    check_eq("abort_entry_a", {16'd0, disp_o}, 32'h0007);

    // Asynchronous reset mid-calculation
    press(4'd10); press(4'd3); press(4'd12);
    #2 rst_i = 1'b1;
    #1;
    check_eq("async_rst", {12'd0, neg_o, ovf_o, busy_o, done_o, disp_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (done_o || busy_o) done_seen++;
    end
    check_eq("rst_no_done", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
